// File: rtl/dense_row_collector_pkg.sv
// Shared matrix-multiply constants: default lane count, element width and index sizing.
package dense_row_collector_pkg;

  localparam int unsigned MM_LANES  = 561;
  localparam int unsigned MM_ELEM_W = 16;

  // Bits needed to hold a lane index; at least one bit so degenerate sizes stay legal.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/onehot_encoder.sv
// One-hot to binary index encoder; o_valid_c is high only when exactly one bit is set.
module onehot_encoder #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     i_onehot,
  output logic [IDX_W-1:0] o_index_c,
  output logic             o_valid_c
);

  logic w_any;
  logic w_multi;

  always_comb begin
    o_index_c = '0;
    w_any     = 1'b0;
    w_multi   = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (i_onehot[k]) begin
        w_multi   = w_multi | w_any;
        w_any     = 1'b1;
        o_index_c = o_index_c | IDX_W'(k);
      end
    end
    o_valid_c = w_any & ~w_multi;
  end

endmodule

// File: rtl/dense_row_collector.sv
// Collects one element per lane as the select rotates and hands each finished row
// to a single-entry holding register with a valid/ready handshake.
module dense_row_collector
  import dense_row_collector_pkg::*;
#(
  parameter int unsigned N = MM_LANES,
  parameter int unsigned W = MM_ELEM_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   sel,
  input  logic           in_valid,
  input  logic [W-1:0]   in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] out_row,
  output logic [N-1:0]   out_mask,
  output logic           err_sel,
  output logic           err_ovf
);

  localparam int unsigned IDX_W = idx_width(N);

  // Lane N-1 is only ever written on a completing cycle, so it bypasses the collect storage.
  logic [(N-1)*W-1:0] r_buf;
  logic [N-2:0]       r_mask;

  logic [IDX_W-1:0] w_idx;
  logic             w_onehot;
  logic             w_wr;
  logic             w_complete;
  logic             w_last_wr;
  logic             w_load;
  logic [W-1:0]     w_top;
  logic [N*W-1:0]   w_row_next;
  logic [N-1:0]     w_mask_next;

  onehot_encoder #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_enc (
    .i_onehot  (sel),
    .o_index_c (w_idx),
    .o_valid_c (w_onehot)
  );

  assign w_wr        = in_valid & w_onehot;
  assign w_complete  = sel[N-1];
  assign w_last_wr   = w_wr & sel[N-1];
  assign w_load      = w_complete & (~out_valid | out_ready);
  assign w_top       = w_last_wr ? in_data : out_row[N*W-1 -: W];
  assign w_row_next  = {w_top, r_buf};
  assign w_mask_next = {w_last_wr, r_mask};

  // Collect data storage; never reset, only qualified by it.
  always_ff @(posedge clk) begin
    if (rst && w_wr) begin
      for (int unsigned k = 0; k < N - 1; k++) begin
        if (w_idx == IDX_W'(k)) begin
          r_buf[k*W +: W] <= in_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mask    <= '0;
      out_valid <= 1'b0;
      out_row   <= '0;
      out_mask  <= '0;
      err_sel   <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      if (w_complete) begin
        r_mask <= '0;
      end else begin
        for (int unsigned k = 0; k < N - 1; k++) begin
          if (w_wr && (w_idx == IDX_W'(k))) begin
            r_mask[k] <= 1'b1;
          end
        end
      end

      // Holding register: load a finished row, or retire the held one on handshake.
      if (w_load) begin
        out_row   <= w_row_next;
        out_mask  <= w_mask_next;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (w_complete && out_valid && !out_ready) begin
        err_ovf <= 1'b1;
      end
      if (in_valid && !w_onehot) begin
        err_sel <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dense_row_collector.sv
// Randomized scoreboard bench for dense_row_collector with a row-level reference model.
module tb_dense_row_collector;

  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   sel;
  logic           in_valid;
  logic [W-1:0]   in_data;
  logic           out_valid;
  logic           out_ready;
  logic [N*W-1:0] out_row;
  logic [N-1:0]   out_mask;
  logic           err_sel;
  logic           err_ovf;

  always #5 clk = ~clk;

  dense_row_collector #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_row   (out_row),
    .out_mask  (out_mask),
    .err_sel   (err_sel),
    .err_ovf   (err_ovf)
  );

  // Model state: collect lanes/mask plus holding register; hk marks lanes with defined data.
  typedef struct packed {
    logic [N*W-1:0] col;
    logic [N-1:0]   cm;
    logic [N*W-1:0] hrow;
    logic [N-1:0]   hk;
    logic [N-1:0]   hm;
    logic           v;
    logic           esel;
    logic           eovf;
  } model_t;

  typedef struct packed {
    logic [N*W-1:0] row;
    logic [N-1:0]   mask;
  } exp_t;

  model_t cur;
  model_t nxt;
  exp_t   q[$];
  exp_t   mon_e;
  int     tests = 0;
  int     fails = 0;
  bit     checking = 1'b0;
  int     pos = 0;

  function automatic logic [N*W-1:0] lanes(input logic [N-1:0] m);
    logic [N*W-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) if (m[k]) r[k*W +: W] = '1;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Next state of the model from the rules: write selected lane, complete on top lane.
  task automatic model_step(input logic r, input logic [N-1:0] s, input logic iv,
                            input logic [W-1:0] d, input logic rdy);
    model_t m;
    exp_t   e;
    m = cur;
    if (!r) begin
      m.cm = '0; m.hrow = '0; m.hk = '1; m.hm = '0;
      m.v = 1'b0; m.esel = 1'b0; m.eovf = 1'b0;
      q.delete();
    end else begin
      if (iv && ($countones(s) != 1)) m.esel = 1'b1;
      if (iv && ($countones(s) == 1)) begin
        for (int k = 0; k < N; k++) begin
          if (s[k]) begin
            m.col[k*W +: W] = d;
            m.cm[k] = 1'b1;
          end
        end
      end
      if (s[N-1]) begin
        if (!cur.v || rdy) begin
          m.hrow = m.col; m.hm = m.cm; m.hk = m.cm; m.v = 1'b1;
          e.row = m.col; e.mask = m.cm;
          q.push_back(e);
        end else begin
          m.eovf = 1'b1;
        end
        m.cm = '0;
      end else if (cur.v && rdy) begin
        m.v = 1'b0;
      end
    end
    nxt = m;
  endtask

  task automatic cycle(input logic r, input logic [N-1:0] s, input logic iv,
                       input logic [W-1:0] d, input logic rdy);
    @(posedge clk);
    #2;
    cur = nxt;
    checking = 1'b1;
    rst = r; sel = s; in_valid = iv; in_data = d; out_ready = rdy;
    model_step(r, s, iv, d, rdy);
  endtask

  task automatic rot(input logic iv, input logic [W-1:0] d, input logic rdy);
    logic [N-1:0] s;
    s = '0;
    s[pos] = 1'b1;
    cycle(1'b1, s, iv, d, rdy);
    pos = (pos + 1) % N;
  endtask

  task automatic do_reset();
    cycle(1'b0, N'($urandom), 1'($urandom), W'($urandom), 1'($urandom));
    pos = 0;
  endtask

  // Monitor: checks visible state each cycle and pops the scoreboard on every accepted row.
  always @(negedge clk) begin
    if (checking) begin
      check("out_valid", 64'(out_valid), 64'(cur.v));
      check("err_sel", 64'(err_sel), 64'(cur.esel));
      check("err_ovf", 64'(err_ovf), 64'(cur.eovf));
      check("out_mask", 64'(out_mask), 64'(cur.hm));
      check("out_row", 64'(out_row & lanes(cur.hk)), 64'(cur.hrow & lanes(cur.hk)));
      if (rst && out_valid && out_ready) begin
        if (q.size() == 0) begin
          tests++; fails++;
          $display("FAIL sb_pop: got row %h with no expected row queued", out_row);
        end else begin
          mon_e = q.pop_front();
          check("sb_mask", 64'(out_mask), 64'(mon_e.mask));
          check("sb_row", 64'(out_row & lanes(mon_e.mask)), 64'(mon_e.row & lanes(mon_e.mask)));
        end
      end
    end
  end

  initial begin
    rst = 1'b0; sel = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    cur = '0; cur.hk = '1;
    nxt = cur;

    do_reset(); do_reset();
    // Full row, always ready.
    rot(1'b1, 8'd11, 1'b1); rot(1'b1, 8'd22, 1'b1); rot(1'b1, 8'd33, 1'b1); rot(1'b1, 8'd44, 1'b1);
    // Hole at lane 2.
    rot(1'b1, 8'd11, 1'b1); rot(1'b1, 8'd22, 1'b1); rot(1'b0, 8'd99, 1'b1); rot(1'b1, 8'd44, 1'b1);
    // Stalled consumer across two rows, then release.
    for (int i = 0; i < 2 * N; i++) rot(1'b1, W'(8'h60 + i), 1'b0);
    rot(1'b1, 8'h70, 1'b1); rot(1'b1, 8'h71, 1'b1);
    // Non-one-hot select in place of lane 2.
    cycle(1'b1, 4'b0110, 1'b1, 8'd55, 1'b1); pos = (pos + 1) % N;
    rot(1'b1, 8'h72, 1'b1);
    // Reset mid-row, then a clean rotation.
    do_reset();
    rot(1'b1, 8'hA0, 1'b1); rot(1'b1, 8'hA1, 1'b1);
    do_reset();
    rot(1'b1, 8'hB0, 1'b1); rot(1'b1, 8'hB1, 1'b1); rot(1'b1, 8'hB2, 1'b1); rot(1'b1, 8'hB3, 1'b1);
    // Completion coinciding with a handshake on the held row.
    rot(1'b1, 8'hC0, 1'b0); rot(1'b1, 8'hC1, 1'b0); rot(1'b1, 8'hC2, 1'b0); rot(1'b1, 8'hC3, 1'b1);
    rot(1'b0, 8'h00, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else if ($urandom_range(0, 49) == 0) begin
        cycle(1'b1, N'($urandom), ($urandom_range(0, 9) != 0), W'($urandom), 1'($urandom));
        pos = (pos + 1) % N;
      end else begin
        rot(($urandom_range(0, 9) < 8), W'($urandom), 1'($urandom));
      end
    end

    @(posedge clk);
    #2;
    cur = nxt;
    check("sb_drain", 64'(q.size()), 64'(cur.v));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
